render_sequencer: RTL and testbench

Frame-level control sequencer for the GPU: it walks a triangle list held in an external synchronous RAM and feeds each triangle to the rasterizer unit with a start pulse. It waits for the rasterizer's done signal between triangles and rotates a 2- or 3-deep set of framebuffers, with the swap optionally aligned to VGA vsync. It sits between the top-level key/mode inputs, the triangle memory, `rasterizer_unit` and `frame_director`, all in the GPU clock domain.

---
 rtl/render_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_render_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/render_sequencer.sv
// render_sequencer
//   Frame-level control sequencer. Walks a triangle list in an external
//   synchronous RAM, hands each triangle to the rasterizer with a start pulse,
//   waits for its done, then rotates the 2- or 3-deep framebuffer set.
//
// Ports
//   clk, reset_n      GPU clock, synchronous active-low reset
//   user_key          debounced start key (already synchronised)
//   continuous        restart the next frame right after each swap
//   tri_count         triangles per frame, clamped to NUM_TRI
//   tri_addr/tri_data triangle RAM port (data one cycle after address)
//   p1/p2/p3          registered vertices {z,y,x}
//   raster_start/done rasterizer handshake
//   vsync             vertical sync pulse
//   buffer_select     back buffer, front_buffer displayed buffer
//   busy, frame_count status
//
// Build option
//   RENDER_SEQ_VSYNC_SWAP_EN  when defined, the swap waits for vsync.

module render_sequencer #(
  parameter int NUM_TRI         = 16,
  parameter int NUM_BUFFERS     = 2,
  parameter int COORD_W         = 32,
  parameter int START_CYCLES    = 4,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         user_key,
  input  logic                         continuous,
  input  logic [$clog2(NUM_TRI+1)-1:0] tri_count,
  output logic [$clog2(NUM_TRI)-1:0]   tri_addr,
  input  logic [9*COORD_W-1:0]         tri_data,
  output logic [3*COORD_W-1:0]         p1,
  output logic [3*COORD_W-1:0]         p2,
  output logic [3*COORD_W-1:0]         p3,
  output logic                         raster_start,
  input  logic                         raster_done,
  input  logic                         vsync,
  output logic [1:0]                   buffer_select,
  output logic [1:0]                   front_buffer,
  output logic                         busy,
  output logic [15:0]                  frame_count
);

  localparam int AW = $clog2(NUM_TRI);
  localparam int CW = $clog2(NUM_TRI+1);
  localparam int DW = $clog2(DEBOUNCE_CYCLES+1);
  localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
  localparam int VW = 3*COORD_W;

  localparam logic [CW-1:0] N_TRI    = CW'(NUM_TRI);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] ST_LAST  = SW'(START_CYCLES-1);
  localparam logic [1:0]    BUF_LAST = 2'(NUM_BUFFERS-1);

  typedef enum logic [3:0] {
    S_IDLE, S_DEBOUNCE, S_FETCH, S_LOAD, S_START,
    S_WAIT, S_NEXT, S_SWAP_WAIT, S_SWAP
  } state_t;

  state_t state_q, state_d;

  logic [DW-1:0] deb_q, deb_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stc_q, stc_d;
  logic [AW-1:0] tri_addr_q, tri_addr_d;
  logic [VW-1:0] p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic          raster_start_q, raster_start_d;
  logic [1:0]    bs_q, bs_d, fb_q, fb_d;
  logic          busy_q, busy_d;
  logic [15:0]   fc_q, fc_d;

  logic [CW-1:0] idx_inc;
  logic          frame_begin;   // entering FETCH for the first triangle
  logic          swap_go;

  assign idx_inc = idx_q + CW'(1);

`ifdef RENDER_SEQ_VSYNC_SWAP_EN
  assign swap_go = vsync;
`else
  assign swap_go = 1'b1;
  logic unused_vsync;
  assign unused_vsync = vsync;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (user_key) state_d = S_DEBOUNCE;
      S_DEBOUNCE:  if (!user_key) state_d = (deb_q >= DEB_MAX) ? S_FETCH : S_IDLE;
      S_FETCH:     state_d = (cnt_q == '0) ? S_SWAP_WAIT : S_LOAD;
      S_LOAD:      state_d = S_START;
      S_START:     if (stc_q == ST_LAST) state_d = S_WAIT;
      S_WAIT:      if (raster_done) state_d = S_NEXT;
      S_NEXT:      state_d = (idx_inc < cnt_q) ? S_FETCH : S_SWAP_WAIT;
      S_SWAP_WAIT: if (swap_go) state_d = S_SWAP;
      S_SWAP:      state_d = continuous ? S_FETCH : S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic. Registered outputs are computed from the next
  // state so they line up with the state they belong to.
  always_comb begin
    deb_d          = deb_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    stc_d          = '0;
    tri_addr_d     = tri_addr_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    p3_d           = p3_q;
    bs_d           = bs_q;
    fb_d           = fb_q;
    fc_d           = fc_q;
    frame_begin    = (state_d == S_FETCH) && (state_q != S_NEXT);

    if (state_q == S_IDLE)
      deb_d = '0;
    else if (state_q == S_DEBOUNCE && user_key && deb_q != DEB_MAX)
      deb_d = deb_q + DW'(1);   // saturates at the threshold

    if (frame_begin) begin
      idx_d = '0;
      cnt_d = (tri_count > N_TRI) ? N_TRI : tri_count;
    end else if (state_q == S_NEXT) begin
      idx_d = idx_inc;
    end

    if (state_q == S_START) stc_d = stc_q + SW'(1);

    // idx is always below NUM_TRI whenever FETCH is entered
    if (state_d == S_FETCH) tri_addr_d = idx_d[AW-1:0];

    if (state_q == S_LOAD) begin
      p1_d = tri_data[VW-1:0];
      p2_d = tri_data[2*VW-1:VW];
      p3_d = tri_data[3*VW-1:2*VW];
    end

    // Both indices move on the same edge, so they can never collide.
    if (state_d == S_SWAP) begin
      fb_d = bs_q;
      bs_d = (bs_q == BUF_LAST) ? 2'd0 : bs_q + 2'd1;
      fc_d = fc_q + 16'd1;
    end

    raster_start_d = (state_d == S_START);
    busy_d         = (state_d != S_IDLE) && (state_d != S_DEBOUNCE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      deb_q          <= '0;
      idx_q          <= '0;
      cnt_q          <= '0;
      stc_q          <= '0;
      tri_addr_q     <= '0;
      p1_q           <= '0;
      p2_q           <= '0;
      p3_q           <= '0;
      raster_start_q <= 1'b0;
      bs_q           <= 2'd1;
      fb_q           <= 2'd0;
      busy_q         <= 1'b0;
      fc_q           <= '0;
    end else begin
      deb_q          <= deb_d;
      idx_q          <= idx_d;
      cnt_q          <= cnt_d;
      stc_q          <= stc_d;
      tri_addr_q     <= tri_addr_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      p3_q           <= p3_d;
      raster_start_q <= raster_start_d;
      bs_q           <= bs_d;
      fb_q           <= fb_d;
      busy_q         <= busy_d;
      fc_q           <= fc_d;
    end
  end

  assign tri_addr      = tri_addr_q;
  assign p1            = p1_q;
  assign p2            = p2_q;
  assign p3            = p3_q;
  assign raster_start  = raster_start_q;
  assign buffer_select = bs_q;
  assign front_buffer  = fb_q;
  assign busy          = busy_q;
  assign frame_count   = fc_q;

endmodule

// File: tb/tb_render_sequencer.sv
module tb_render_sequencer;
  localparam int CWD = 32;
  localparam int NT  = 16;

  logic clk = 0, reset_n = 0, user_key = 0, continuous = 0;
  logic raster_done = 0, vsync = 0;
  logic [4:0]       tri_count = 0;
  logic [3:0]       tri_addr;
  logic [9*CWD-1:0] tri_data;
  logic [3*CWD-1:0] p1, p2, p3;
  logic             raster_start, busy;
  logic [1:0]       bs, fb;
  logic [15:0]      fc;

  // 3-buffer instance, continuous mode, rasterizer always done
  logic             key3 = 0, cont3 = 0, done3 = 1, vsync3 = 1;
  logic [2:0]       tri_count3 = 3'd1;
  logic [1:0]       tri_addr3;
  logic [9*CWD-1:0] tri_data3;
  logic [3*CWD-1:0] q1, q2, q3;
  logic             rs3, busy3;
  logic [1:0]       bs3, fb3;
  logic [15:0]      fc3;

  logic [9*CWD-1:0] ram [NT];

  render_sequencer dut (
    .clk(clk), .reset_n(reset_n), .user_key(user_key), .continuous(continuous),
    .tri_count(tri_count), .tri_addr(tri_addr), .tri_data(tri_data),
    .p1(p1), .p2(p2), .p3(p3), .raster_start(raster_start),
    .raster_done(raster_done), .vsync(vsync), .buffer_select(bs),
    .front_buffer(fb), .busy(busy), .frame_count(fc)
  );

  render_sequencer #(.NUM_TRI(4), .NUM_BUFFERS(3), .START_CYCLES(2),
                     .DEBOUNCE_CYCLES(4)) dut3 (
    .clk(clk), .reset_n(reset_n), .user_key(key3), .continuous(cont3),
    .tri_count(tri_count3), .tri_addr(tri_addr3), .tri_data(tri_data3),
    .p1(q1), .p2(q2), .p3(q3), .raster_start(rs3),
    .raster_done(done3), .vsync(vsync3), .buffer_select(bs3),
    .front_buffer(fb3), .busy(busy3), .frame_count(fc3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tri_data  <= ram[tri_addr];
    tri_data3 <= ram[tri_addr3];
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Rasterizer model: done pulse 10 cycles after each start rise
  int pulses = 0, run_len = 0, min_len = 1000, max_len = 0, dly = 0, max_addr = 0;
  logic rs_prev = 0;
  bit busy_seen = 0;
  logic [95:0] cap1 [32], cap2 [32], cap3 [32];

  initial forever begin
    @(negedge clk);
    raster_done = 0;
    if (!reset_n) begin
      dly = 0;
      rs_prev = 0;
    end else begin
      if (dly > 0) begin
        dly--;
        if (dly == 0) raster_done = 1;
      end
      if (raster_start && !rs_prev) begin
        if (pulses < 32) begin
          cap1[pulses] = p1; cap2[pulses] = p2; cap3[pulses] = p3;
        end
        pulses++;
        run_len = 1;
        dly = 10;
      end else if (raster_start) begin
        run_len++;
      end
      if (!raster_start && rs_prev) begin
        if (run_len < min_len) min_len = run_len;
        if (run_len > max_len) max_len = run_len;
      end
      rs_prev = raster_start;
    end
    if (busy) busy_seen = 1;
    if (int'(tri_addr) > max_addr) max_addr = int'(tri_addr);
  end

  task automatic press(input int n);
    @(negedge clk);
    user_key = 1;
    repeat (n) @(negedge clk);
    user_key = 0;
  endtask

  task automatic wait_frame(input logic [15:0] n);
    int t = 0;
    bit ok = 0;
    while (t < 5000 && !ok) begin
      @(negedge clk);
      if (fc == n && !busy) ok = 1;
      t++;
    end
    chk("frame_wait", ok, 1);
  endtask

  initial begin
    int lat, t;
    bit ok;
    logic [1:0] exp_bs3 [4], exp_fb3 [4];
    exp_bs3[0] = 2; exp_fb3[0] = 1;
    exp_bs3[1] = 0; exp_fb3[1] = 2;
    exp_bs3[2] = 1; exp_fb3[2] = 0;
    exp_bs3[3] = 2; exp_fb3[3] = 1;

    for (int i = 0; i < NT; i++)
      for (int j = 0; j < 9; j++)
        ram[i][j*CWD +: CWD] = 32'h3f80_0000 + 32'(i*256 + j);

    // reset state
    reset_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_start", raster_start, 0);
    chk("rst_addr", tri_addr, 0);
    chk("rst_p1", p1, 0);
    chk("rst_p3", p3, 0);
    chk("rst_bs", bs, 1);
    chk("rst_fb", fb, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", fc, 0);
    reset_n = 1;

    // two-triangle frame
    tri_count = 2;
    press(1100);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (raster_start && lat == 0) lat = k;
    end
    chk("key_to_start", lat, 3);
    wait_frame(1);
    chk("f1_pulses", pulses, 2);
    chk("f1_minlen", min_len, 4);
    chk("f1_maxlen", max_len, 4);
    chk("f1_t0_p1", cap1[0], ram[0][95:0]);
    chk("f1_t0_p2", cap2[0], ram[0][191:96]);
    chk("f1_t1_p3", cap3[1], ram[1][287:192]);
    chk("f1_t1_p1", cap1[1], ram[1][95:0]);
    chk("f1_fb", fb, 1);
    chk("f1_bs", bs, 0);
    chk("f1_fc", fc, 1);

    // short press: rejected
    busy_seen = 0;
    press(500);
    repeat (20) @(negedge clk);
    chk("short_busy", busy_seen, 0);
    chk("short_pulses", pulses, 2);
    chk("short_fc", fc, 1);

    // empty frame still swaps
    tri_count = 0;
    press(1100);
    wait_frame(2);
    chk("empty_pulses", pulses, 2);
    chk("empty_fb", fb, 0);
    chk("empty_bs", bs, 1);

    // clamp 20 -> 16
    tri_count = 20;
    max_addr = 0;
    press(1100);
    wait_frame(3);
    chk("clamp_pulses", pulses, 18);
    chk("clamp_maxaddr", max_addr, 15);
    chk("clamp_t15_p1", cap1[17], ram[15][95:0]);
    chk("clamp_t0_p2", cap2[2], ram[0][191:96]);
    chk("clamp_fb", fb, 1);
    chk("clamp_bs", bs, 0);

    // reset during WAIT
    tri_count = 2;
    press(1100);
    t = 0; ok = 0;
    while (t < 200 && !ok) begin
      @(negedge clk);
      if (pulses == 19 && !raster_start) ok = 1;
      t++;
    end
    chk("reach_wait", ok, 1);
    reset_n = 0;
    @(negedge clk);
    chk("mrst_start", raster_start, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_fc", fc, 0);
    chk("mrst_fb", fb, 0);
    chk("mrst_bs", bs, 1);
    chk("mrst_p1", p1, 0);
    chk("mrst_addr", tri_addr, 0);
    @(negedge clk);
    reset_n = 1;
    tri_count = 1;
    press(1100);
    wait_frame(1);
    chk("post_pulses", pulses, 20);
    chk("post_p1", cap1[19], ram[0][95:0]);
    chk("post_fb", fb, 1);
    chk("post_bs", bs, 0);

`ifdef RENDER_SEQ_VSYNC_SWAP_EN
    // swap held for vsync
    press(1100);
    t = 0; ok = 0;
    while (t < 200 && !ok) begin
      @(negedge clk);
      if (pulses == 21) ok = 1;
      t++;
    end
    chk("vs_pulse", ok, 1);
    repeat (12 + 50) @(negedge clk);
    chk("vs_hold_fc", fc, 1);
    chk("vs_hold_busy", busy, 1);
    vsync = 1;
    @(negedge clk);
    vsync = 0;
    chk("vs_fc", fc, 2);
    chk("vs_fb", fb, 0);
    chk("vs_bs", bs, 1);
`endif

    // 3-buffer continuous rotation
    cont3 = 1;
    @(negedge clk);
    key3 = 1;
    repeat (8) @(negedge clk);
    key3 = 0;
    for (int n = 1; n <= 4; n++) begin
      t = 0; ok = 0;
      while (t < 300 && !ok) begin
        @(negedge clk);
        if (fc3 == 16'(n)) ok = 1;
        t++;
      end
      chk("rot_wait", ok, 1);
      chk("rot_bs", bs3, exp_bs3[n-1]);
      chk("rot_fb", fb3, exp_fb3[n-1]);
      if (n == 3) begin
        @(negedge clk);
        cont3 = 0;
      end
    end
    repeat (30) @(negedge clk);
    chk("rot_fc", fc3, 4);
    chk("rot_busy", busy3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
